// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder: one digit per clock through a shared digit stage, LSD first.
// Optional BCD_DIGIT_CHECK_EN adds a sticky err output flagging non-decimal input digits.
module bcd_serial_add_ctrl #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] A,
  input  logic [4*NDIG-1:0] B,
  output logic [4*NDIG-1:0] S,
  output logic              Co,
  output logic              busy,
`ifdef BCD_DIGIT_CHECK_EN
  output logic              err,
`endif
  output logic              done
);

  localparam int W  = 4 * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);

  // Single-digit decimal add: returns {carry_out, digit}
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
    logic [4:0] t;
    logic [4:0] adj;
    logic [4:0] res;
    t = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    adj = t + 5'd6;
    if (t > 5'd9) begin
      res = {1'b1, adj[3:0]};
    end else begin
      res = {1'b0, t[3:0]};
    end
    return res;
  endfunction

  logic [1:0]    state_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  s_r;
  logic [IW-1:0] idx_r;
  logic          carry_r;
  logic          co_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;

  logic [3:0]    dig_a_s;
  logic [3:0]    dig_b_s;
  logic [4:0]    sum_s;
  logic          bad_dig_s;

  // Select the current digit pair and run it through the shared adder stage
  always_comb begin
    dig_a_s   = a_r[{idx_r, 2'b00} +: 4];
    dig_b_s   = b_r[{idx_r, 2'b00} +: 4];
    sum_s     = bcd_digit_add(dig_a_s, dig_b_s, carry_r);
    bad_dig_s = (dig_a_s > 4'd9) || (dig_b_s > 4'd9);
  end

  // Sequencer: operand capture, per-digit accumulation and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      co_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= A;
            b_r     <= B;
            idx_r   <= '0;
            carry_r <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_ADD;
          end
        end
        ST_ADD: begin
          s_r[{idx_r, 2'b00} +: 4] <= sum_s[3:0];
          carry_r <= sum_s[4];
          err_r   <= err_r | bad_dig_s;
          if (idx_r == IDX_LAST) begin
            co_r    <= sum_s[4];
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign S    = s_r;
  assign Co   = co_r;
  assign busy = busy_r;
  assign done = done_r;
`ifdef BCD_DIGIT_CHECK_EN
  assign err  = err_r;
`else
  // Check flag is still tracked internally but has no consumer in this build
  logic unused_err_s;
  assign unused_err_s = err_r;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: directed table, corner sequences, random ops
// checked against a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] S;
  logic         Co;
  logic         busy;
  logic         done;
`ifdef BCD_DIGIT_CHECK_EN
  logic         err;
`endif

  int checks = 0;
  int errors = 0;

  bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .S    (S),
    .Co   (Co),
    .busy (busy),
`ifdef BCD_DIGIT_CHECK_EN
    .err  (err),
`endif
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal value of a packed-BCD word (valid digits only)
  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One full operation with latency, result and pulse-width checks
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] es, input logic eco, input string name);
    int n;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(NDIG + 1));
    chk({name, "_S"}, 32'(S), 32'(es));
    chk({name, "_Co"}, 32'(Co), 32'(eco));
    chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
    chk({name, "_S_hold"}, 32'(S), 32'(es));
  endtask

  initial begin
    int n;
    int cnt;
    logic [W-1:0] s_seen;
    logic [W-1:0] ra, rb;
    int sum;

    vecs[0] = '{16'h1234, 16'h5678, 16'h6912, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{16'h0999, 16'h0999, 16'h1998, 1'b0};
    vecs[4] = '{16'h9999, 16'h9999, 16'h9998, 1'b1};
    vecs[5] = '{16'h5000, 16'h5000, 16'h0000, 1'b1};
    vecs[6] = '{16'h000F, 16'h0001, 16'h0016, 1'b0};

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("reset_S", 32'(S), 32'd0);
    chk("reset_Co", 32'(Co), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].co, "table");

    // Back-to-back with start held high
    @(negedge clk);
    A = 16'h0000; B = 16'h0000; start = 1'b1;
    @(negedge clk);
    A = 16'h0999; B = 16'h0999;
    n = 1;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("b2b_first_latency", 32'(n), 32'(NDIG + 1));
    chk("b2b_first_S", 32'(S), 32'h0000);
    chk("b2b_first_Co", 32'(Co), 32'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    start = 1'b0;
    chk("b2b_spacing", 32'(n), 32'(NDIG + 2));
    chk("b2b_second_S", 32'(S), 32'h1998);
    chk("b2b_second_Co", 32'(Co), 32'd0);
    @(negedge clk);
    chk("b2b_done_pulse", 32'(done), 32'd0);

    // start during ADD is ignored
    @(negedge clk);
    A = 16'h1234; B = 16'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'h9999; B = 16'h9999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; s_seen = '0;
    for (int i = 0; i < 3 * NDIG; i++) begin
      if (done) begin cnt++; s_seen = S; end
      @(negedge clk);
    end
    chk("ignore_done_count", 32'(cnt), 32'd1);
    chk("ignore_S", 32'(s_seen), 32'h6912);

    // Reset in the second ADD cycle
    @(negedge clk);
    A = 16'h9999; B = 16'h9999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_S", 32'(S), 32'd0);
    chk("midrst_Co", 32'(Co), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    cnt = 0;
    for (int i = 0; i < 2 * NDIG; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("midrst_no_done", 32'(cnt), 32'd0);
    run_op(16'h4321, 16'h1234, 16'h5555, 1'b0, "after_rst");

    // Random valid-BCD operands against decimal arithmetic
    for (int k = 0; k < 30; k++) begin
      ra = '0; rb = '0;
      for (int d = 0; d < NDIG; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      sum = bcd_to_int(ra) + bcd_to_int(rb);
      run_op(ra, rb, int_to_bcd(sum % 10000), (sum >= 10000), "random");
    end

`ifdef BCD_DIGIT_CHECK_EN
    run_op(16'h00A0, 16'h0001, 16'h0101, 1'b0, "err_bad");
    chk("err_set", 32'(err), 32'd1);
    run_op(16'h0001, 16'h0001, 16'h0002, 1'b0, "err_good");
    chk("err_clear", 32'(err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
